softmax_row_max: RTL and testbench

Streaming row-maximum stage of the softmax datapath. It accepts one row of `NUM_WORDS` signed 16-bit fixed-point scores, `NUM` lanes per beat, and reduces them to a single row maximum. It presents that maximum on a valid/ready handshake to the downstream 4-lane subtract stage, which uses it as the common `b` operand for every lane.

---
 rtl/softmax_row_max.sv | 98 +++++++++
 tb/tb_softmax_row_max.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_max.sv
// Streaming row-maximum reducer for the softmax datapath: folds NUM-lane beats
// into one signed maximum per row and hands it downstream on a valid/ready port.
module softmax_row_max #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int NUM_WORDS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data0,
  input  logic [DATAWIDTH-1:0] in_data1,
  input  logic [DATAWIDTH-1:0] in_data2,
  input  logic [DATAWIDTH-1:0] in_data3,
  output logic [DATAWIDTH-1:0] max_out,
  output logic                 max_valid,
  input  logic                 max_ready,
  output logic                 busy,
  output logic                 row_done
);

  localparam int BEATS = NUM_WORDS / NUM;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [CW-1:0]                beat_cnt;
  logic signed [DATAWIDTH-1:0]  run_max;
  logic signed [DATAWIDTH-1:0]  m01;
  logic signed [DATAWIDTH-1:0]  m23;
  logic signed [DATAWIDTH-1:0]  lane_max;
  logic                         beat_accept;
  logic                         last_beat;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. Both ready/valid outputs decode from state alone, so neither
  // in_valid nor max_ready can reach them combinationally.
  assign in_ready  = (state == ST_ACCUM);
  assign max_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);
  assign row_done  = (state == ST_HOLD) && max_ready;
  assign max_out   = run_max;

  assign beat_accept = (state == ST_ACCUM) && in_valid;
  assign last_beat   = beat_accept && (beat_cnt == LAST_BEAT);

  // Two-level signed compare tree; ties keep either operand, the value is equal.
  always_comb begin
    m01      = ($signed(in_data0) > $signed(in_data1)) ? in_data0 : in_data1;
    m23      = ($signed(in_data2) > $signed(in_data3)) ? in_data2 : in_data3;
    lane_max = (m01 > m23) ? m01 : m23;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)     state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_beat) state_nxt = ST_HOLD;
      ST_HOLD:  if (max_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Beat 0 loads the lane max directly so no sentinel is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      run_max  <= '0;
    end else if ((state == ST_IDLE) && start) begin
      beat_cnt <= '0;
    end else if (beat_accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
      if (beat_cnt == '0) begin
        run_max <= lane_max;
      end else if (lane_max > run_max) begin
        run_max <= lane_max;
      end
    end
  end

endmodule

// File: tb/tb_softmax_row_max.sv
// Bench for softmax_row_max: random and directed rows checked against a plain
// maximum-of-array reference through an expected-result queue.
module tb_softmax_row_max;

  localparam int DW        = 16;
  localparam int NUM       = 4;
  localparam int NUM_WORDS = 32;
  localparam int BEATS     = NUM_WORDS / NUM;

  typedef logic [DW-1:0] row_t [0:NUM_WORDS-1];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data0 = '0;
  logic [DW-1:0] in_data1 = '0;
  logic [DW-1:0] in_data2 = '0;
  logic [DW-1:0] in_data3 = '0;
  logic [DW-1:0] max_out;
  logic          max_valid;
  logic          max_ready = 1'b1;
  logic          busy;
  logic          row_done;

  logic [DW-1:0] exp_q [$];
  int            n_vec  = 0;
  int            n_fail = 0;

  softmax_row_max #(
    .DATAWIDTH(DW),
    .NUM(NUM),
    .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data0(in_data0),
    .in_data1(in_data1),
    .in_data2(in_data2),
    .in_data3(in_data3),
    .max_out(max_out),
    .max_valid(max_valid),
    .max_ready(max_ready),
    .busy(busy),
    .row_done(row_done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, required 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_max(input row_t r);
    int m;
    m = int'($signed(r[0]));
    for (int i = 1; i < NUM_WORDS; i++)
      if (int'($signed(r[i])) > m) m = int'($signed(r[i]));
    return m[DW-1:0];
  endfunction

  task automatic gen_row(output row_t r, input int lo, input int hi);
    int v;
    for (int i = 0; i < NUM_WORDS; i++) begin
      v = int'($urandom_range(hi - lo, 0)) + lo;
      r[i] = v[DW-1:0];
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && max_valid && max_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", max_out, ~max_out);
      end else begin
        check("max_out", max_out, exp_q.pop_front());
        check("row_done_on_handshake", {15'd0, row_done}, 16'd1);
      end
    end
  end

  // ---------------- drivers (all called at a negedge) ----------------
  task automatic send_row(input row_t r, input int nbeats, input bit bubbles);
    bit rdy;
    int guard;
    if (nbeats == BEATS) exp_q.push_back(ref_max(r));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", {15'd0, in_ready}, 16'd1);
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles) begin
        while ($urandom_range(2, 0) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      check("no_early_valid", {15'd0, max_valid}, 16'd0);
      in_valid = 1'b1;
      in_data0 = r[b*NUM + 0];
      in_data1 = r[b*NUM + 1];
      in_data2 = r[b*NUM + 2];
      in_data3 = r[b*NUM + 3];
      rdy = in_ready;
      guard = 0;
      while (!rdy && guard < 20) begin
        @(negedge clk);
        rdy = in_ready;
        guard++;
      end
      if (!rdy) check("beat_accept_timeout", {15'd0, in_ready}, 16'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (nbeats == BEATS) begin
      check("max_valid_latency", {15'd0, max_valid}, 16'd1);
      check("in_ready_in_hold", {15'd0, in_ready}, 16'd0);
      check("busy_in_hold", {15'd0, busy}, 16'd1);
    end
  endtask

  task automatic wait_done(input logic [DW-1:0] last_max);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
    end
    @(negedge clk);
    check("busy_after_row", {15'd0, busy}, 16'd0);
    check("max_valid_after_row", {15'd0, max_valid}, 16'd0);
    check("row_done_idle", {15'd0, row_done}, 16'd0);
    check("max_out_retained", max_out, last_max);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    row_t r;
    row_t r2;
    logic [DW-1:0] e;

    // reset state
    @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_max_valid", {15'd0, max_valid}, 16'd0);
    check("rst_max_out", max_out, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_row_done", {15'd0, row_done}, 16'd0);
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_ignores_in_valid", {15'd0, in_ready}, 16'd0);
    in_valid = 1'b0;

    // monotonic row
    for (int i = 0; i < NUM_WORDS; i++) r[i] = 16'(i);
    send_row(r, BEATS, 1'b0);
    wait_done(16'h001F);

    // all negative, max in beat 0 lane 2
    gen_row(r, -32768, -256);
    r[2] = 16'hFFFF;
    send_row(r, BEATS, 1'b0);
    wait_done(16'hFFFF);

    // all minimum
    for (int i = 0; i < NUM_WORDS; i++) r[i] = 16'h8000;
    send_row(r, BEATS, 1'b1);
    wait_done(16'h8000);

    // signed extremes with bubbles
    r[5*NUM + 3] = 16'h7FFF;
    send_row(r, BEATS, 1'b1);
    wait_done(16'h7FFF);

    // downstream backpressure, start during HOLD ignored
    gen_row(r, -32768, 32767);
    e = ref_max(r);
    max_ready = 1'b0;
    send_row(r, BEATS, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("bp_max_valid", {15'd0, max_valid}, 16'd1);
      check("bp_max_out", max_out, e);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      check("bp_row_done", {15'd0, row_done}, 16'd0);
      start = (c == 3);
      @(negedge clk);
    end
    start = 1'b0;
    @(posedge clk);
    #1 max_ready = 1'b1;
    @(negedge clk);
    wait_done(e);
    check("start_in_hold_ignored", {15'd0, in_ready}, 16'd0);

    // reset mid-row, then a clean row with max 0x0042
    for (int i = 0; i < NUM_WORDS; i++) r[i] = 16'h7000;
    send_row(r, 4, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {15'd0, in_ready}, 16'd0);
    check("midrst_max_valid", {15'd0, max_valid}, 16'd0);
    check("midrst_max_out", max_out, 16'h0000);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_row_done", {15'd0, row_done}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    gen_row(r, -32768, 66);
    r[$urandom_range(NUM_WORDS - 1, 0)] = 16'h0042;
    send_row(r, BEATS, 1'b0);
    wait_done(16'h0042);

    // back-to-back rows: 0x1234 then 0x0011
    gen_row(r, -32768, 16'h1234);
    r[17] = 16'h1234;
    gen_row(r2, -32768, 16'h0011);
    r2[30] = 16'h0011;
    send_row(r, BEATS, 1'b0);
    wait_done(16'h1234);
    send_row(r2, BEATS, 1'b1);
    wait_done(16'h0011);

    // random rows
    for (int k = 0; k < 12; k++) begin
      gen_row(r, -32768, 32767);
      e = ref_max(r);
      send_row(r, BEATS, k[0]);
      wait_done(e);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
